cmd_frame_parser: RTL and testbench
===================================

// Module: cmd_frame_parser
// PURPOSE
//  Consumer of the selected comm-link RX FIFO (rec_command/com_count/com_pop) in the cores-switch design.
//  Pops bytes and parses framed commands. Valid frames are replayed verbatim into the shared CPU A/B UART TX path (tdr_cpuAB/tf_push_cpuAB).
//  Switch frames drive force_swi/com_swi. Bad frames raise error, which drives led5.
// PARAMETERS
//  CNT_W        5      width of com_count; equals `UART_FIFO_COUNTER_W
//  MAX_PAYLOAD  12     max LEN value; a full frame (4+LEN bytes) fits the 16-deep UART TX FIFO
//  HDR0         8'hEB  first sync byte
//  HDR1         8'h90  second sync byte
//  SWI_TYPE     8'h5A  payload[0] value marking a switch command
// PORTS
//  clk                 in   1      system clock
//  rst_n               in   1      asynchronous active-low reset
//  rec_command         in   8      RX FIFO head byte, show-ahead, valid while com_count!=0
//  com_count           in   CNT_W  RX FIFO occupancy
//  com_pop             out  1      1-cycle pop strobe
//  command_time_out_d  in   1      inter-frame idle timeout pulse from both links
//  tdr_cpuAB           out  8      byte to CPU UART TX FIFOs
//  tf_push_cpuAB       out  1      1-cycle push strobe, tdr_cpuAB valid same cycle
//  force_swi           out  1      1-cycle pulse: apply com_swi
//  com_swi             out  1      commanded target, 0=CPU A, 1=CPU B (level, held)
//  error               out  1      sticky frame-error flag
// BEHAVIOUR
//  Reset: com_pop=0, tf_push_cpuAB=0, tdr_cpuAB=0, force_swi=0, com_swi=0, error=0; FSM=HUNT0; buffer index=0.
//  Frame format: HDR0 HDR1 LEN PAYLOAD[LEN] CSUM. CSUM = (LEN + sum of payload bytes) mod 256.
//  Pop rule: in a receiving state with com_count!=0 and no pop in the previous cycle, assert com_pop for 1 cycle.
//    rec_command is captured in that same cycle. Max rate: 1 byte per 2 clocks, so com_count settles before the next pop.
//  Every captured byte is written to the frame buffer at idx, idx++. HUNT0 restarts at idx=0.
//  FSM transitions:
//    HUNT0: byte==HDR0 -> HUNT1; otherwise discard.
//    HUNT1: byte==HDR1 -> LEN; byte==HDR0 -> stay in HUNT1 (idx=1); otherwise -> HUNT0.
//    LEN:   1..MAX_PAYLOAD -> BODY, sum=LEN; 0 or >MAX_PAYLOAD -> error=1, -> HUNT0.
//    BODY:  sum+=byte; after LEN bytes -> CSUM.
//    CSUM:  byte==sum -> CHECK; mismatch -> error=1, -> HUNT0.
//    CHECK (1 cycle, no pop): error=0.
//      LEN>=2 and payload[0]==SWI_TYPE -> SWITCH.
//      Otherwise -> SEND.
//    SWITCH (1 cycle): com_swi<=payload[1][0]; force_swi=1 next cycle for exactly 1 cycle. Frame is not forwarded. -> HUNT0.
//    SEND: push buffer[0..LEN+3], one byte per cycle, tf_push_cpuAB high for LEN+4 consecutive cycles. No pops during SEND. -> HUNT0.
//  Timeout: command_time_out_d=1 in HUNT1/LEN/BODY/CSUM -> error=1, -> HUNT0, partial frame dropped.
//    In HUNT0/CHECK/SWITCH/SEND the timeout is ignored; SEND always completes.
//  Simultaneous timeout and pop capture: timeout wins and the captured byte is discarded.
//  Arithmetic: sum is 8-bit wrap-around. idx is 4-bit and never exceeds MAX_PAYLOAD+3.
//  Reset mid-frame or mid-SEND: outputs return to reset values immediately; no partial push continues.
//  error stays high until the next valid frame completes CHECK.
// CONFIGURATION
//  CMD_SWITCH_EN defined: SWITCH decoding active as above.
//  CMD_SWITCH_EN undefined: the SWITCH state is not built. force_swi=0 and com_swi=0 constantly. Every valid frame goes to SEND.
// STRUCTURE
//  Shared include cmd_defines.v holds:
//    FSM state encodings (3-bit: HUNT0,HUNT1,LEN,BODY,CSUM,CHECK,SWITCH,SEND)
//    HDR0/HDR1/SWI_TYPE defaults and MAX_PAYLOAD.
//  Sub-module cmd_frame_buf: 16x8 register file with 1 write port (idx, captured byte) and 1 async read port (send index / payload[0..1]).
// TESTING
//  1. EB 90 02 11 22 35 in FIFO -> 6 pops spaced >=2 clks; then 6 consecutive tf_push with tdr=EB,90,02,11,22,35; error=0.
//  2. EB 90 02 5A 01 5D (CMD_SWITCH_EN) -> com_swi=1, one force_swi pulse, zero tf_push; repeat with 5A 00 5C -> com_swi=0.
//  3. EB 90 01 10 99 (bad CSUM) -> error=1, no push. Then EB 90 01 10 11 -> error=0 and 5 pushes.
//  4. LEN=0x0D or LEN=0 -> error=1, FSM back in HUNT0. A following valid frame is accepted.
//  5. EB 90 03 01 then command_time_out_d pulse -> error=1, no push. Junk 00 EB EB 90 01 07 08 -> frame found, pushes EB,90,01,07,08.
//  6. rst_n low mid-SEND (after 2 pushes) -> tf_push_cpuAB=0 immediately; com_swi=0; FSM in HUNT0 after release.

Source files
------------

// File: rtl/cmd_frame_parser_pkg.sv
// Shared constants, FSM state encoding and helpers for the command frame parser.
package cmd_frame_parser_pkg;

  localparam int unsigned CNT_W_DEF       = 5;
  localparam int unsigned MAX_PAYLOAD_DEF = 12;
  localparam logic [7:0]  HDR0_DEF        = 8'hEB;
  localparam logic [7:0]  HDR1_DEF        = 8'h90;
  localparam logic [7:0]  SWI_TYPE_DEF    = 8'h5A;

  typedef enum logic [2:0] {
    StHunt0  = 3'd0,
    StHunt1  = 3'd1,
    StLen    = 3'd2,
    StBody   = 3'd3,
    StCsum   = 3'd4,
    StCheck  = 3'd5,
    StSwitch = 3'd6,
    StSend   = 3'd7
  } state_e;

  // States in which the parser pulls bytes from the RX FIFO.
  function automatic logic is_rx_state(input state_e s);
    return (s == StHunt0) || (s == StHunt1) || (s == StLen) || (s == StBody) || (s == StCsum);
  endfunction

  // States in which an idle timeout aborts the frame in progress.
  function automatic logic is_timeout_state(input state_e s);
    return (s == StHunt1) || (s == StLen) || (s == StBody) || (s == StCsum);
  endfunction

endpackage

// File: rtl/cmd_frame_buf.sv
// 16x8 frame buffer: one synchronous write port, one asynchronous read port.
module cmd_frame_buf (
  input  logic       i_clk,
  input  logic       i_we,
  input  logic [3:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [3:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [16];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cmd_frame_parser.sv
// Parses EB 90 LEN PAYLOAD CSUM frames from the RX FIFO and replays valid ones to the CPU UART.
// Define CMD_SWITCH_EN to decode switch frames into force_swi/com_swi.
module cmd_frame_parser
  import cmd_frame_parser_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned MAX_PAYLOAD = MAX_PAYLOAD_DEF,
  parameter logic [7:0]  HDR0        = HDR0_DEF,
  parameter logic [7:0]  HDR1        = HDR1_DEF,
  parameter logic [7:0]  SWI_TYPE    = SWI_TYPE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rec_command,
  input  logic [CNT_W-1:0] com_count,
  output logic             com_pop,
  input  logic             command_time_out_d,
  output logic [7:0]       tdr_cpuAB,
  output logic             tf_push_cpuAB,
  output logic             force_swi,
  output logic             com_swi,
  output logic             error
);

  localparam logic [7:0] MaxLen = 8'(MAX_PAYLOAD);

  state_e     r_state, w_state_nx;
  logic [3:0] r_idx, w_idx_nx;
  logic [3:0] r_len, w_len_nx;
  logic [7:0] r_sum, w_sum_nx;
  logic       r_error, w_error_nx;
  logic       r_popped;
  logic       w_pop, w_timeout, w_we;
  logic [3:0] w_raddr;
  logic [7:0] w_rdata;

  // Pop at most every other cycle so com_count has settled before the next pop.
  assign w_pop     = is_rx_state(r_state) && (com_count != '0) && !r_popped;
  assign w_timeout = command_time_out_d && is_timeout_state(r_state);
  assign w_we      = w_pop && !w_timeout;

  always_comb begin
    unique case (r_state)
      StCheck:  w_raddr = 4'd3;
      StSwitch: w_raddr = 4'd4;
      default:  w_raddr = r_idx;
    endcase
  end

  cmd_frame_buf u_buf (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (rec_command),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StHunt0;
      r_idx    <= 4'd0;
      r_len    <= 4'd0;
      r_sum    <= 8'd0;
      r_error  <= 1'b0;
      r_popped <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_idx    <= w_idx_nx;
      r_len    <= w_len_nx;
      r_sum    <= w_sum_nx;
      r_error  <= w_error_nx;
      r_popped <= w_pop;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_len_nx   = r_len;
    w_sum_nx   = r_sum;
    w_error_nx = r_error;
    if (w_timeout) begin
      w_error_nx = 1'b1;
      w_state_nx = StHunt0;
      w_idx_nx   = 4'd0;
    end else begin
      unique case (r_state)
        StHunt0: begin
          w_idx_nx = 4'd0;
          if (w_we && rec_command == HDR0) begin
            w_state_nx = StHunt1;
            w_idx_nx   = 4'd1;
          end
        end
        StHunt1: begin
          if (w_we) begin
            if (rec_command == HDR1) begin
              w_state_nx = StLen;
              w_idx_nx   = 4'd2;
            end else if (rec_command == HDR0) begin
              w_idx_nx   = 4'd1;
            end else begin
              w_state_nx = StHunt0;
              w_idx_nx   = 4'd0;
            end
          end
        end
        StLen: begin
          if (w_we) begin
            if (rec_command != 8'd0 && rec_command <= MaxLen) begin
              w_state_nx = StBody;
              w_len_nx   = rec_command[3:0];
              w_sum_nx   = rec_command;
              w_idx_nx   = 4'd3;
            end else begin
              w_error_nx = 1'b1;
              w_state_nx = StHunt0;
              w_idx_nx   = 4'd0;
            end
          end
        end
        StBody: begin
          if (w_we) begin
            w_sum_nx = r_sum + rec_command;
            w_idx_nx = r_idx + 4'd1;
            // Last payload byte sits at index LEN+2; idx then points at the CSUM slot.
            if (r_idx == r_len + 4'd2) begin
              w_state_nx = StCsum;
            end
          end
        end
        StCsum: begin
          if (w_we) begin
            if (rec_command == r_sum) begin
              w_state_nx = StCheck;
            end else begin
              w_error_nx = 1'b1;
              w_state_nx = StHunt0;
              w_idx_nx   = 4'd0;
            end
          end
        end
        StCheck: begin
          w_error_nx = 1'b0;
          w_idx_nx   = 4'd0;
          w_state_nx = StSend;
`ifdef CMD_SWITCH_EN
          if (r_len >= 4'd2 && w_rdata == SWI_TYPE) begin
            w_state_nx = StSwitch;
          end
`endif
        end
        StSwitch: begin
          w_state_nx = StHunt0;
          w_idx_nx   = 4'd0;
        end
        StSend: begin
          if (r_idx == r_len + 4'd3) begin
            w_state_nx = StHunt0;
            w_idx_nx   = 4'd0;
          end else begin
            w_idx_nx = r_idx + 4'd1;
          end
        end
        default: begin
          w_state_nx = StHunt0;
          w_idx_nx   = 4'd0;
        end
      endcase
    end
  end

  assign com_pop       = w_pop;
  assign tf_push_cpuAB = (r_state == StSend);
  assign tdr_cpuAB     = tf_push_cpuAB ? w_rdata : 8'h00;
  assign error         = r_error;

`ifdef CMD_SWITCH_EN
  logic r_com_swi, r_force_swi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_com_swi   <= 1'b0;
      r_force_swi <= 1'b0;
    end else begin
      if (r_state == StSwitch) begin
        r_com_swi <= w_rdata[0];
      end
      r_force_swi <= (r_state == StSwitch);
    end
  end

  assign com_swi   = r_com_swi;
  assign force_swi = r_force_swi;
`else
  assign com_swi   = 1'b0;
  assign force_swi = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Self-checking bench for cmd_frame_parser: directed frames plus randomized frames against a frame-level model.
module tb_cmd_frame_parser;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rec_command = 8'h00;
  logic [4:0] com_count = 5'd0;
  logic       com_pop;
  logic       command_time_out_d = 1'b0;
  logic [7:0] tdr_cpuAB;
  logic       tf_push_cpuAB;
  logic       force_swi;
  logic       com_swi;
  logic       error;

  int n_tests = 0;
  int n_fail = 0;

  cmd_frame_parser dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rec_command        (rec_command),
    .com_count          (com_count),
    .com_pop            (com_pop),
    .command_time_out_d (command_time_out_d),
    .tdr_cpuAB          (tdr_cpuAB),
    .tf_push_cpuAB      (tf_push_cpuAB),
    .force_swi          (force_swi),
    .com_swi            (com_swi),
    .error              (error)
  );

  always #5 clk = ~clk;

  // Show-ahead RX FIFO model and output monitor, all updated mid-cycle.
  logic [7:0] fifo[$];
  logic [7:0] got[$];
  logic       pop_mark = 1'b0;
  logic       prev_pop = 1'b0;
  logic [7:0] junk;
  int         run_len = 0;
  int         last_run = 0;
  int         n_force = 0;
  int         pop_viol = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pop_mark = 1'b0;
      prev_pop = 1'b0;
      run_len  = 0;
    end else begin
      if (pop_mark && fifo.size() != 0) junk = fifo.pop_front();
      pop_mark = com_pop;
      if (com_pop && prev_pop) pop_viol++;
      prev_pop = com_pop;
      if (tf_push_cpuAB) begin
        got.push_back(tdr_cpuAB);
        run_len++;
      end else if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
      if (force_swi) n_force++;
    end
    rec_command = (fifo.size() != 0) ? fifo[0] : 8'h00;
    com_count   = 5'(fifo.size());
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t make_frame(input bq_t payload, input logic bad_csum);
    bq_t        f;
    logic [7:0] s;
    s = 8'(payload.size());
    f = '{8'hEB, 8'h90, 8'(payload.size())};
    foreach (payload[i]) begin
      f.push_back(payload[i]);
      s = s + payload[i];
    end
    f.push_back(bad_csum ? (s ^ 8'h01) : s);
    return f;
  endfunction

  function automatic logic is_switch(input bq_t payload);
`ifdef CMD_SWITCH_EN
    return payload.size() >= 2 && payload[0] == 8'h5A;
`else
    return 1'b0;
`endif
  endfunction

  task automatic feed(input bq_t b);
    foreach (b[i]) fifo.push_back(b[i]);
  endtask

  task automatic settle();
    int t = 0;
    while (fifo.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("fifo_drain", 32'(fifo.size()), 32'd0);
    repeat (30) @(negedge clk);
  endtask

  task automatic expect_forward(input string tag, input bq_t f);
    check({tag, "_npush"}, 32'(got.size()), 32'(f.size()));
    if (got.size() == f.size()) begin
      foreach (f[i]) check({tag, "_byte"}, 32'(got[i]), 32'(f[i]));
    end
    check({tag, "_run"}, 32'(last_run), 32'(f.size()));
    check({tag, "_err"}, 32'(error), 32'd0);
    got.delete();
  endtask

  // Frame-level reference: a frame is forwarded, switched or rejected.
  task automatic expect_frame(input string tag, input bq_t payload, input logic bad,
                              inout logic exp_swi, inout int exp_force);
    bq_t f;
    f = make_frame(payload, bad);
    if (bad) begin
      check({tag, "_bad_npush"}, 32'(got.size()), 32'd0);
      check({tag, "_bad_err"}, 32'(error), 32'd1);
      got.delete();
    end else if (is_switch(payload)) begin
      exp_swi = payload[1][0];
      exp_force++;
      check({tag, "_sw_npush"}, 32'(got.size()), 32'd0);
      check({tag, "_sw_err"}, 32'(error), 32'd0);
    end else begin
      expect_forward(tag, f);
    end
    check({tag, "_comswi"}, 32'(com_swi), 32'(exp_swi));
    check({tag, "_force"}, 32'(n_force), 32'(exp_force));
  endtask

  initial begin
    bq_t  p, f;
    logic exp_swi = 1'b0;
    int   exp_force = 0;
    int   k;
    int   t;

    repeat (3) @(negedge clk);
    check("rst_pop", 32'(com_pop), 32'd0);
    check("rst_push", 32'(tf_push_cpuAB), 32'd0);
    check("rst_tdr", 32'(tdr_cpuAB), 32'd0);
    check("rst_force", 32'(force_swi), 32'd0);
    check("rst_comswi", 32'(com_swi), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain forward.
    p = '{8'h11, 8'h22};
    feed(make_frame(p, 1'b0));
    settle();
    expect_frame("t1", p, 1'b0, exp_swi, exp_force);

    // Switch frames (forwarded when switch decoding is not built).
    p = '{8'h5A, 8'h01};
    feed(make_frame(p, 1'b0));
    settle();
    expect_frame("t2a", p, 1'b0, exp_swi, exp_force);
    p = '{8'h5A, 8'h00};
    feed(make_frame(p, 1'b0));
    settle();
    expect_frame("t2b", p, 1'b0, exp_swi, exp_force);

    // Bad checksum, then good.
    p = '{8'h10};
    feed('{8'hEB, 8'h90, 8'h01, 8'h10, 8'h99});
    settle();
    expect_frame("t3a", p, 1'b1, exp_swi, exp_force);
    feed(make_frame(p, 1'b0));
    settle();
    expect_frame("t3b", p, 1'b0, exp_swi, exp_force);

    // Out-of-range LEN values.
    feed('{8'hEB, 8'h90, 8'h0D});
    settle();
    check("t4_len13_err", 32'(error), 32'd1);
    check("t4_len13_npush", 32'(got.size()), 32'd0);
    p = '{8'h01, 8'h02, 8'h03};
    feed(make_frame(p, 1'b0));
    settle();
    expect_frame("t4b", p, 1'b0, exp_swi, exp_force);
    feed('{8'hEB, 8'h90, 8'h00});
    settle();
    check("t4_len0_err", 32'(error), 32'd1);
    p = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9, 8'hAA, 8'hAB};
    feed(make_frame(p, 1'b0));
    settle();
    expect_frame("t4_max", p, 1'b0, exp_swi, exp_force);

    // Timeout mid-frame, then resync through junk and repeated HDR0.
    feed('{8'hEB, 8'h90, 8'h03, 8'h01});
    settle();
    check("t5_pre_err", 32'(error), 32'd0);
    command_time_out_d = 1'b1;
    @(negedge clk);
    command_time_out_d = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_to_err", 32'(error), 32'd1);
    check("t5_to_npush", 32'(got.size()), 32'd0);
    feed('{8'h00, 8'hEB, 8'hEB, 8'h90, 8'h01, 8'h07, 8'h08});
    settle();
    expect_forward("t5_resync", '{8'hEB, 8'h90, 8'h01, 8'h07, 8'h08});

    // Randomized frames with leading junk and occasional bad checksums.
    for (int it = 0; it < 12; it++) begin
      logic bad;
      int   len;
      p.delete();
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) p.push_back(8'($urandom));
      if ($urandom_range(0, 3) == 0) p[0] = 8'h5A;
      bad = ($urandom_range(0, 3) == 0);
      for (int j = $urandom_range(0, 3); j > 0; j--) begin
        logic [7:0] jb;
        jb = 8'($urandom);
        if (jb == 8'hEB) jb = 8'h00;
        fifo.push_back(jb);
      end
      feed(make_frame(p, bad));
      settle();
      expect_frame("rnd", p, bad, exp_swi, exp_force);
    end

    // Reset in the middle of SEND.
    p = '{8'h5A, 8'h01};
    feed(make_frame(p, 1'b0));
    settle();
    expect_frame("t6_pre", p, 1'b0, exp_swi, exp_force);
    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    feed(make_frame(p, 1'b0));
    k = 0;
    t = 0;
    while (k < 2 && t < 200) begin
      @(posedge clk);
      #1;
      if (tf_push_cpuAB) k++;
      t++;
    end
    check("t6_saw_push", 32'(k), 32'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_push", 32'(tf_push_cpuAB), 32'd0);
    check("t6_rst_tdr", 32'(tdr_cpuAB), 32'd0);
    check("t6_rst_comswi", 32'(com_swi), 32'd0);
    check("t6_rst_pop", 32'(com_pop), 32'd0);
    fifo.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got.delete();
    exp_swi = 1'b0;
    n_force = 0;
    exp_force = 0;
    @(negedge clk);
    p = '{8'h44};
    feed(make_frame(p, 1'b0));
    settle();
    expect_frame("t6_post", p, 1'b0, exp_swi, exp_force);

    check("pop_spacing", 32'(pop_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
